// File: rtl/oh_arb_pkg.sv
// oh_arb_pkg: shared constants, state encoding and index helper for the 4-way round-robin arbiter
package oh_arb_pkg;

    localparam int NREQ = 4;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return 2'((32'(idx) + 1) % NREQ);
    endfunction

endpackage

// File: rtl/oh_arb4_rrpick.sv
// oh_arb4_rrpick: combinational round-robin pick (rotate, find-first, un-rotate) over masked requests
module oh_arb4_rrpick
    import oh_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    input  logic [NREQ-1:0] mask,
    output logic [NREQ-1:0] onehot,
    output logic [1:0]      idx,
    output logic            any
);

    logic [NREQ-1:0] m;
    logic [NREQ-1:0] rot;
    logic [1:0]      first;

    assign m      = req & mask;
    assign rot    = 4'({m, m} >> ptr);
    assign first  = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    assign idx    = first + ptr;
    assign any    = |m;
    assign onehot = any ? 4'b0001 << idx : 4'b0000;

endmodule

// File: rtl/oh_arb4_rr.sv
// oh_arb4_rr: 4-requester round-robin arbiter, registered one-hot grant, optional bounded hold (stats via OH_ARB4_STATS_EN)
module oh_arb4_rr
    import oh_arb_pkg::*;
#(
    parameter     PROP    = "DEFAULT",
    parameter int MAXHOLD = 0,
    parameter int CW      = 8
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] lock,
    output logic [NREQ-1:0] grant,
    output logic            valid,
    output logic [1:0]      owner
`ifdef OH_ARB4_STATS_EN
    ,
    output logic [NREQ*CW-1:0] stats
`endif
);

    localparam int            HW   = MAXHOLD > 1 ? $clog2(MAXHOLD) : 1;
    localparam logic [HW-1:0] HMAX = HW'(MAXHOLD - 1);

    arb_state_t      state, state_n;
    logic [1:0]      ptr, ptr_n, owner_n, pick_idx;
    logic [HW-1:0]   hold_cnt, hold_n;
    logic [NREQ-1:0] grant_n, pick_oh;
    logic            pick_any, busy, release_c, preempt, rearb;

    assign busy      = state == ARB_BUSY;
    assign release_c = busy && !req[owner];
    assign preempt   = busy && MAXHOLD > 0 && hold_cnt == HMAX && !lock[owner] && |(req & ~grant);
    assign rearb     = !busy || release_c || preempt;
    assign valid     = |grant;

    oh_arb4_rrpick u_pick (
        .req    (req),
        .ptr    (ptr),
        .mask   (~grant),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // next state: hold the owner, or re-arbitrate on idle/release/preemption excluding the current owner
    always_comb begin
        state_n = state;
        grant_n = grant;
        owner_n = owner;
        ptr_n   = ptr;
        hold_n  = hold_cnt == HMAX ? hold_cnt : hold_cnt + 1'b1;
        if (rearb) begin
            hold_n  = '0;
            state_n = en && pick_any ? ARB_BUSY : ARB_IDLE;
            grant_n = en && pick_any ? pick_oh : '0;
            owner_n = en && pick_any ? pick_idx : 2'd0;
            ptr_n   = en && pick_any ? next_idx(pick_idx) : ptr;
        end
    end

    // state, pointer, hold counter and grant registers
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state    <= ARB_IDLE;
            grant    <= '0;
            owner    <= 2'd0;
            ptr      <= 2'd0;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            owner    <= owner_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
        end
    end

`ifdef OH_ARB4_STATS_EN
    logic [NREQ-1:0] rise;

    assign rise = grant_n & ~grant;

    // per-master saturating count of grant rising edges
    always_ff @(posedge clk) begin
        if (!nreset) begin
            stats <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (rise[i] && stats[i*CW +: CW] != {CW{1'b1}})
                    stats[i*CW +: CW] <= stats[i*CW +: CW] + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_oh_arb4_rr.sv
// tb_oh_arb4_rr: vector table, hand sequences and randomized comparison against a behavioural round-robin model
module tb_oh_arb4_rr;

    localparam int MH = 4;
    localparam int CW = 2;

    typedef struct {
        logic       nrst;
        logic       en;
        logic [3:0] req;
        logic [3:0] lock;
        logic [3:0] grant;
    } vec_t;

    logic       clk = 1'b0;
    logic       nreset, en;
    logic [3:0] req, lock, grant;
    logic       valid;
    logic [1:0] owner;
`ifdef OH_ARB4_STATS_EN
    logic [4*CW-1:0] stats;
`endif

    int   checks = 0, failures = 0;
    int   m_own = -1, m_ptr = 0, m_cnt = 0;
    vec_t tv[$];

    always #5 clk = ~clk;

    oh_arb4_rr #(.PROP("DEFAULT"), .MAXHOLD(MH), .CW(CW)) dut (
        .clk    (clk),
        .nreset (nreset),
        .en     (en),
        .req    (req),
        .lock   (lock),
        .grant  (grant),
        .valid  (valid),
        .owner  (owner)
`ifdef OH_ARB4_STATS_EN
        ,
        .stats  (stats)
`endif
    );

    function automatic int pick(logic [3:0] r, int p, int excl);
        for (int k = 0; k < 4; k++) begin
            int j = (p + k) % 4;
            if (r[j] && j != excl) return j;
        end
        return -1;
    endfunction

    task automatic model_step();
        if (!nreset) begin
            m_own = -1;
            m_ptr = 0;
            m_cnt = 0;
        end else if (m_own < 0 || !req[m_own] ||
                     (m_cnt >= MH - 1 && !lock[m_own] && (req & ~(4'b0001 << m_own)) != 4'b0)) begin
            m_own = en ? pick(req, m_ptr, m_own) : -1;
            m_cnt = 0;
            if (m_own >= 0) m_ptr = (m_own + 1) % 4;
        end else begin
            m_cnt++;
        end
    endtask

    function automatic logic [3:0] m_grant();
        return m_own < 0 ? 4'b0 : 4'(1 << m_own);
    endfunction

    function automatic logic [1:0] oh2i(logic [3:0] g);
        for (int k = 0; k < 4; k++) if (g[k]) return 2'(k);
        return 2'd0;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic add(logic r, logic e, logic [3:0] q, logic [3:0] l, logic [3:0] g);
        tv.push_back('{r, e, q, l, g});
    endtask

    initial begin
        add(0, 1, 4'hF, 4'h0, 4'b0000);
        add(0, 1, 4'hF, 4'h0, 4'b0000);
        add(1, 1, 4'hF, 4'h0, 4'b0001);
        add(1, 1, 4'hF, 4'h0, 4'b0001);
        add(1, 1, 4'hE, 4'h0, 4'b0010);
        add(1, 1, 4'hF, 4'h0, 4'b0010);
        add(1, 1, 4'hD, 4'h0, 4'b0100);
        add(1, 1, 4'hF, 4'h0, 4'b0100);
        add(1, 1, 4'hB, 4'h0, 4'b1000);
        add(1, 1, 4'hF, 4'h0, 4'b1000);
        add(1, 1, 4'h7, 4'h0, 4'b0001);
        add(1, 1, 4'h0, 4'h0, 4'b0000);
        add(1, 1, 4'h9, 4'h0, 4'b1000);
        add(1, 1, 4'h1, 4'h0, 4'b0001);
        add(1, 1, 4'h0, 4'h0, 4'b0000);
        add(1, 1, 4'h1, 4'h0, 4'b0001);
        add(1, 1, 4'h3, 4'h0, 4'b0001);
        add(1, 1, 4'h3, 4'h0, 4'b0001);
        add(1, 1, 4'h3, 4'h0, 4'b0001);
        add(1, 1, 4'h3, 4'h0, 4'b0010);
        add(1, 1, 4'h1, 4'h1, 4'b0001);
        for (int n = 0; n < 6; n++) add(1, 1, 4'h3, 4'h1, 4'b0001);
        add(1, 1, 4'h0, 4'hF, 4'b0000);
        add(1, 1, 4'h4, 4'hF, 4'b0100);
        add(1, 0, 4'hF, 4'hF, 4'b0100);
        add(1, 0, 4'hF, 4'hF, 4'b0100);
        add(1, 0, 4'hB, 4'hF, 4'b0000);
        add(1, 0, 4'hF, 4'hF, 4'b0000);
        add(1, 1, 4'hF, 4'hF, 4'b1000);
        add(0, 1, 4'hF, 4'h0, 4'b0000);
        add(1, 1, 4'hF, 4'h0, 4'b0001);

        foreach (tv[i]) begin
            nreset = tv[i].nrst;
            en     = tv[i].en;
            req    = tv[i].req;
            lock   = tv[i].lock;
            cyc();
            chk($sformatf("vec%0d grant", i), 32'(grant), 32'(tv[i].grant));
            chk($sformatf("vec%0d valid", i), 32'(valid), 32'(|tv[i].grant));
            chk($sformatf("vec%0d owner", i), 32'(owner), 32'(oh2i(tv[i].grant)));
        end

        for (int n = 0; n < 3000; n++) begin
            nreset = $urandom_range(0, 99) != 0;
            en     = $urandom_range(0, 9) != 0;
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            lock   = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'h0;
            cyc();
            chk("rnd grant", 32'(grant), 32'(m_grant()));
            chk("rnd owner", 32'(owner), 32'(m_own < 0 ? 0 : m_own));
            chk("rnd valid", 32'(valid), 32'(m_own >= 0));
        end

`ifdef OH_ARB4_STATS_EN
        nreset = 1'b0;
        en     = 1'b1;
        req    = 4'h0;
        lock   = 4'h0;
        cyc();
        chk("stats reset", 32'(stats), 32'h0);
        nreset = 1'b1;
        for (int n = 0; n < 5; n++) begin
            req = 4'b0010;
            cyc();
            req = 4'b0000;
            cyc();
        end
        chk("stats sat", 32'(stats), 32'h0C);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
